// File: rtl/monitor_rq_ack_mc.sv
// rtl/monitor_rq_ack_mc.sv - multi-channel req/ack protocol monitor
// Flags unstable, withdrawn, unrequested, simultaneous and timed-out handshakes.
module monitor_rq_ack_mc #(
  parameter int CH      = 2,
  parameter int REQ_DW  = 4,
  parameter int ACK_DW  = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CH-1:0]          req,
  input  logic [CH-1:0]          ack,
  input  logic [CH*REQ_DW-1:0]   req_data,
  input  logic [CH*ACK_DW-1:0]   ack_data,
  output logic [CH-1:0]          err_pulse,
  output logic [CH*5-1:0]        err_sticky,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W-1:0]       xfer_cnt
);

  typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;

  localparam logic [15:0] TO   = 16'(TIMEOUT);
  localparam int          EV_W = 6;
  localparam int          SW   = CNT_W + EV_W;

  state_t                st_q   [CH];
  state_t                st_n   [CH];
  logic [15:0]           wcnt_q [CH];
  logic [15:0]           wcnt_n [CH];
  logic [CH*REQ_DW-1:0]  data_d;
  logic [CH*5-1:0]       ev;
  logic [CH-1:0]         xf;
  logic [EV_W-1:0]       n_err;
  logic [EV_W-1:0]       n_xf;
  logic [SW-1:0]         err_sum;
  logic [SW-1:0]         xf_sum;
  logic                  unused_ack;

  assign unused_ack = ^ack_data;

  always_comb begin
    ev    = '0;
    xf    = '0;
    n_err = '0;
    n_xf  = '0;
    for (int c = 0; c < CH; c++) begin
      st_n[c]   = st_q[c];
      wcnt_n[c] = wcnt_q[c];
      case (st_q[c])
        IDLE: begin
          if (req[c] && ack[c]) begin
            ev[c*5+3] = 1'b1;
            st_n[c]   = DONE;
          end else if (req[c]) begin
            st_n[c]   = PEND;
            wcnt_n[c] = 16'd1;
          end else if (ack[c]) begin
            ev[c*5+2] = 1'b1;
          end
        end
        PEND: begin
          if (req[c]) begin
            if (req_data[c*REQ_DW +: REQ_DW] != data_d[c*REQ_DW +: REQ_DW])
              ev[c*5+0] = 1'b1;
            if (ack[c]) begin
              xf[c]     = 1'b1;
              st_n[c]   = DONE;
              wcnt_n[c] = '0;
            end else if (wcnt_q[c] < TO) begin
              wcnt_n[c] = wcnt_q[c] + 16'd1;
            end
          end else begin
            ev[c*5+1] = 1'b1;
            ev[c*5+2] = ack[c];
            st_n[c]   = IDLE;
            wcnt_n[c] = '0;
          end
        end
        DONE: begin
          if (!req[c]) begin
            ev[c*5+2] = ack[c];
            st_n[c]   = IDLE;
          end else if (!ack[c]) begin
            st_n[c]   = PEND;
            wcnt_n[c] = 16'd1;
          end else begin
            xf[c] = 1'b1;
          end
        end
        default: st_n[c] = IDLE;
      endcase
      // Fire only on the transition into TO, so a saturated wait never repeats it
      if (TO != 16'd0 && st_n[c] == PEND && wcnt_n[c] == TO &&
          (st_q[c] != PEND || wcnt_q[c] != TO))
        ev[c*5+4] = 1'b1;
      if (!en) begin
        st_n[c]       = IDLE;
        wcnt_n[c]     = '0;
        ev[c*5 +: 5]  = '0;
        xf[c]         = 1'b0;
      end
    end
    for (int i = 0; i < CH*5; i++) n_err = n_err + EV_W'(ev[i]);
    for (int c = 0; c < CH; c++)   n_xf  = n_xf + EV_W'(xf[c]);
    err_sum = SW'(err_cnt) + SW'(n_err);
    xf_sum  = SW'(xfer_cnt) + SW'(n_xf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        st_q[c]   <= IDLE;
        wcnt_q[c] <= '0;
      end
      data_d     <= '0;
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
      xfer_cnt   <= '0;
    end else begin
      data_d <= req_data;
      for (int c = 0; c < CH; c++) begin
        st_q[c]      <= st_n[c];
        wcnt_q[c]    <= wcnt_n[c];
        err_pulse[c] <= |ev[c*5 +: 5];
      end
      if (clr) begin
        err_sticky <= '0;
        err_cnt    <= '0;
        xfer_cnt   <= '0;
      end else if (en) begin
        err_sticky <= err_sticky | ev;
        err_cnt    <= (|err_sum[SW-1:CNT_W]) ? '1 : err_sum[CNT_W-1:0];
        xfer_cnt   <= (|xf_sum[SW-1:CNT_W])  ? '1 : xf_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_monitor_rq_ack_mc.sv
// tb/tb_monitor_rq_ack_mc.sv - directed bench for monitor_rq_ack_mc
// Two channels, TIMEOUT=4, CNT_W=4; expected values computed by hand.
module tb_monitor_rq_ack_mc;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [1:0]  req, ack;
  logic [7:0]  req_data, ack_data;
  logic [1:0]  err_pulse;
  logic [9:0]  err_sticky;
  logic [3:0]  err_cnt, xfer_cnt;

  int vectors = 0;
  int miscompares = 0;

  monitor_rq_ack_mc #(
    .CH(2), .REQ_DW(4), .ACK_DW(4), .TIMEOUT(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .req(req), .ack(ack), .req_data(req_data), .ack_data(ack_data),
    .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    req = 2'b00; ack = 2'b00; req_data = 8'h00; ack_data = 8'h00;
    step(); step();
    chk("rst_pulse",  32'(err_pulse),  32'h0);
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_errcnt", 32'(err_cnt),    32'h0);
    chk("rst_xfer",   32'(xfer_cnt),   32'h0);
    rst = 1'b0;

    // clean transfer on ch0
    req = 2'b01; req_data = 8'h0A;
    step(); chk("t1_pulse_e1", 32'(err_pulse), 32'h0);
    step(); chk("t1_pulse_e2", 32'(err_pulse), 32'h0);
    ack = 2'b01;
    step(); chk("t1_pulse_e3", 32'(err_pulse), 32'h0);
    chk("t1_xfer", 32'(xfer_cnt), 32'h1);
    req = 2'b00; ack = 2'b00;
    step(); chk("t1_pulse_e4", 32'(err_pulse), 32'h0);
    chk("t1_errcnt", 32'(err_cnt), 32'h0);
    chk("t1_xfer_hold", 32'(xfer_cnt), 32'h1);

    // unstable data while pending
    req = 2'b01; req_data = 8'h0A;
    step();
    req_data = 8'h05;
    step();
    chk("t2_pulse",  32'(err_pulse),  32'h1);
    chk("t2_sticky", 32'(err_sticky), 32'h001);
    chk("t2_errcnt", 32'(err_cnt),    32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t2_pulse_drop", 32'(err_pulse), 32'h0);
    chk("t2_clr_sticky", 32'(err_sticky), 32'h0);
    chk("t2_clr_errcnt", 32'(err_cnt), 32'h0);
    chk("t2_clr_xfer", 32'(xfer_cnt), 32'h0);

    // ch0 withdraws while ch1 sees unrequested ack
    req = 2'b00; ack = 2'b10;
    step();
    chk("t3_pulse",  32'(err_pulse),  32'h3);
    chk("t3_sticky", 32'(err_sticky), 32'h082);
    chk("t3_errcnt", 32'(err_cnt),    32'h2);
    ack = 2'b00;
    step();
    chk("t3_pulse_drop", 32'(err_pulse), 32'h0);

    // timeout after exactly 4 edges, reported once
    clr = 1'b1; step(); clr = 1'b0;
    req = 2'b01; req_data = 8'h0A;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t4_sticky_e%0d", i), 32'(err_sticky), (i >= 4) ? 32'h010 : 32'h0);
      chk($sformatf("t4_pulse_e%0d", i),  32'(err_pulse),  (i == 4) ? 32'h1 : 32'h0);
    end
    chk("t4_errcnt", 32'(err_cnt), 32'h1);
    req = 2'b00; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_pulse",  32'(err_pulse),  32'h1);
    chk("t4_clr_errcnt", 32'(err_cnt),    32'h0);
    chk("t4_clr_sticky", 32'(err_sticky), 32'h0);

    // saturation of err_cnt with 2 errors per cycle
    ack = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("t5_errcnt_%0d", i), 32'(err_cnt), (2*i > 15) ? 32'd15 : 32'(2*i));
    end
    chk("t5_sticky", 32'(err_sticky), 32'h084);
    ack = 2'b00; clr = 1'b1;
    step();
    chk("t5_clr_errcnt", 32'(err_cnt), 32'h0);
    req = 2'b01; ack = 2'b01;
    step();
    clr = 1'b0;
    chk("t5_simul_pulse",  32'(err_pulse),  32'h1);
    chk("t5_simul_errcnt", 32'(err_cnt),    32'h0);
    chk("t5_simul_sticky", 32'(err_sticky), 32'h0);
    step();
    chk("t5_done_xfer",  32'(xfer_cnt),  32'h1);
    chk("t5_done_pulse", 32'(err_pulse), 32'h0);
    req = 2'b00; ack = 2'b00;
    step();
    chk("t5_idle_errcnt", 32'(err_cnt), 32'h0);

    // reset mid-request, request held through release
    clr = 1'b1; step(); clr = 1'b0;
    req = 2'b01; req_data = 8'h0A;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_xfer", 32'(xfer_cnt), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("t6_pulse_e%0d", i), 32'(err_pulse), (i == 4) ? 32'h1 : 32'h0);
    end
    chk("t6_sticky", 32'(err_sticky), 32'h010);
    chk("t6_errcnt", 32'(err_cnt),    32'h1);

    // disable holds flags and counters
    en = 1'b0; req = 2'b00; ack = 2'b01;
    step();
    chk("t7_pulse",  32'(err_pulse),  32'h0);
    chk("t7_sticky", 32'(err_sticky), 32'h010);
    chk("t7_errcnt", 32'(err_cnt),    32'h1);
    en = 1'b1; req = 2'b01; ack = 2'b00;
    step();
    chk("t7_reentry_pulse", 32'(err_pulse), 32'h0);
    req = 2'b00;
    step();
    chk("t7_withdraw_errcnt", 32'(err_cnt),    32'h2);
    chk("t7_withdraw_sticky", 32'(err_sticky), 32'h012);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/monitor_rq_ack_mc.md
MONITOR_RQ_ACK_MC -- requirements
Module: monitor_rq_ack_mc

Interface
REQ-001 Parameter CH, default 2: number of independent req/ack channels monitored, 1..8.
REQ-002 Parameter REQ_DW, default 4: request data width per channel, 1..32.
REQ-003 Parameter ACK_DW, default 4: acknowledge data width per channel, 1..32; carried for future use, no check applied.
REQ-004 Parameter TIMEOUT, default 16: max cycles a request may wait for ack, 0..65535; 0 disables the timeout check.
REQ-005 Parameter CNT_W, default 8: width of the error and transfer counters, 4..32.
REQ-006 Port clk  input  1  clock; all logic on rising edge. One clock; reset is synchronous and active-high.
REQ-007 Port rst  input  1  synchronous reset, active-high.
REQ-008 Port en  input  1  monitoring enable.
REQ-009 Port clr  input  1  synchronous clear of sticky flags and counters.
REQ-010 Port req  input  CH  per-channel request, level, active 1.
REQ-011 Port ack  input  CH  per-channel acknowledge, pulse, active 1.
REQ-012 Port req_data  input  CH*REQ_DW  channel c in bits [c*REQ_DW +: REQ_DW].
REQ-013 Port ack_data  input  CH*ACK_DW  channel c in bits [c*ACK_DW +: ACK_DW].
REQ-014 Port err_pulse  output  CH  1-cycle pulse, any error on channel c.
REQ-015 Port err_sticky  output  CH*5  bit c*5+t set by error type t on channel c.
REQ-016 Port err_cnt  output  CNT_W  total error events, saturating.
REQ-017 Port xfer_cnt  output  CNT_W  total valid transfers, saturating.

Function
REQ-018 Error types SHALL be: t0 UNSTABLE, t1 WITHDRAW, t2 NOREQ, t3 SIMUL, t4 TIMEOUT.
REQ-019 Each channel SHALL run its own FSM {IDLE, PEND, DONE} and keep a registered copy data_d of its req_data.
REQ-020 IDLE: req=0,ack=1 -> NOREQ, stay IDLE; req=1,ack=0 -> PEND; req=1,ack=1 -> SIMUL, go DONE, not counted as a transfer.
REQ-021 PEND: req=1,ack=0 -> stay PEND; req=1,ack=1 -> count one transfer, go DONE; req=0 -> WITHDRAW, plus NOREQ if ack=1, go IDLE.
REQ-022 PEND with req=1: req_data != data_d -> UNSTABLE, checked whether ack is 0 or 1.
REQ-023 DONE: req=0 -> IDLE, plus NOREQ if ack=1; req=1,ack=0 -> PEND (back-to-back); req=1,ack=1 -> count one transfer, stay DONE, no error.
REQ-024 Wait counter SHALL load 1 on entry to PEND and increment each cycle PEND holds with ack=0, saturating at TIMEOUT.
REQ-025 TIMEOUT error SHALL fire once per request, on the edge where the wait counter reaches TIMEOUT; it SHALL never fire when TIMEOUT=0.
REQ-026 All outputs SHALL be registered; an error or transfer detected on edge k SHALL be visible on outputs after edge k.
REQ-027 err_cnt SHALL add the number of error events across all channels and types in a cycle, 0..5*CH, and saturate at 2^CNT_W-1.
REQ-028 xfer_cnt SHALL add the number of transfers counted in a cycle and saturate at 2^CNT_W-1.
REQ-029 clr=1 SHALL zero err_sticky, err_cnt and xfer_cnt and drop that cycle's events from them; FSMs and err_pulse SHALL be unaffected.
REQ-030 en=0 SHALL force every FSM to IDLE, wait counters to 0 and err_pulse to 0, and SHALL hold sticky flags and counters.

Reset
REQ-031 rst=1 SHALL take priority over en and clr and set all FSMs to IDLE, wait counters, data_d, err_pulse, err_sticky, err_cnt and xfer_cnt to 0.
REQ-032 Reset mid-request SHALL discard the pending state; req=1,ack=0 on the first edge after reset -> PEND, no error.

Verification
REQ-033 ch0: req=1 data=A for 3 cycles, ack on the 3rd, req=0 -> xfer_cnt=1, err_cnt=0, err_pulse never set.
REQ-034 ch0 pending, data A->5 with ack=0 -> err_sticky[0]=1, err_pulse[0] for 1 cycle, err_cnt=1.
REQ-035 ch1 IDLE ack=1 while ch0 withdraws unacked on the same edge -> err_sticky[7]=1, err_sticky[1]=1, err_cnt=2.
REQ-036 TIMEOUT=4, req held 10 cycles with no ack -> err_sticky[4]=1, err_cnt=1 only, flag set exactly 4 edges after req rises.
REQ-037 CNT_W=4, 20 errors forced -> err_cnt=15; clr pulse -> 0; SIMUL in clr cycle -> err_pulse set, err_cnt stays 0.
REQ-038 rst asserted during PEND, req still 1 after release -> no WITHDRAW or TIMEOUT before that request's own TIMEOUT expires.
